// File: rtl/corr_frame_pkg.sv
// Shared frame-layout constants, state encoding and trailer helpers for the
// correlator frame receiver.
package corr_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_TRAILER = 2'd2
  } frame_state_e;

  localparam int TRAILER_LEN = 8;

  // Byte offsets of the trailer fields, counted from the first trailer byte
  localparam int TRL_ACTIVE_LINE_OFS = 0;
  localparam int TRL_DELAY_LINES_OFS = 4;
  localparam int TRL_NUM_INPUTS_OFS  = 5;
  localparam int TRL_RESOLUTION_OFS  = 6;
  localparam int TRL_PAD_OFS         = 7;

  // Cross-correlation words for every input pair and tap, plus one auto-count per input
  function automatic int num_words(input int num_inputs, input int delay_lines);
    return num_inputs * (num_inputs - 1) / 2 * delay_lines + num_inputs;
  endfunction

  function automatic int payload_bytes(input int num_inputs, input int delay_lines,
                                       input int resolution);
    return num_words(num_inputs, delay_lines) * resolution / 8;
  endfunction

  // Value a well-formed sender places at a given trailer offset; the active_line
  // bytes carry data and are never compared
  function automatic logic [7:0] trailer_expect(input int ofs, input int delay_lines,
                                                input int num_inputs, input int resolution);
    logic [7:0] val;
    val = 8'h00;
    case (ofs)
      TRL_DELAY_LINES_OFS: val = delay_lines[7:0];
      TRL_NUM_INPUTS_OFS:  val = num_inputs[7:0];
      TRL_RESOLUTION_OFS:  val = resolution[7:0];
      TRL_PAD_OFS:         val = 8'h00;
      default:             val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/corr_frame_rx_word_asm.sv
// corr_word_assembler: gathers little-endian bytes into one RESOLUTION-bit word
// and flags, combinationally, the byte that completes it.
module corr_word_assembler
  import corr_frame_pkg::*;
#(
  parameter int RESOLUTION = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [7:0]            byte_in,
  input  logic                  byte_vld,
  output logic [RESOLUTION-1:0] word,
  output logic                  word_done
);

  localparam int BPW = RESOLUTION / 8;
  localparam int PW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [PW-1:0] POS_LAST = PW'(BPW - 1);

  logic [PW-1:0]         pos;
  logic [RESOLUTION-1:0] shreg;

  // Newest byte enters at the top so the first byte ends up least significant
  always_comb begin
    word = shreg >> 8;
    word[RESOLUTION-1 -: 8] = byte_in;
  end

  assign word_done = byte_vld && (pos == POS_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pos <= '0;
    end else if (byte_vld) begin
      pos <= (pos == POS_LAST) ? '0 : pos + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (byte_vld) begin
      shreg <= word;
    end
  end

endmodule

// File: rtl/corr_frame_rx.sv
// corr_frame_rx: decodes correlator UART frames into indexed counter words with
// a one-deep output buffer, trailer validation and silent-line timeout.
module corr_frame_rx
  import corr_frame_pkg::*;
#(
  parameter int RESOLUTION   = 16,
  parameter int NUM_INPUTS   = 8,
  parameter int DELAY_LINES  = 51,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic [RESOLUTION-1:0] word_data,
  output logic [15:0]           word_index,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [31:0]           active_line,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int PAYLOAD_BYTES = payload_bytes(NUM_INPUTS, DELAY_LINES, RESOLUTION);
  localparam logic [31:0] PB_LAST  = 32'(PAYLOAD_BYTES - 1);
  localparam logic [31:0] TO_LAST  = 32'(IDLE_TIMEOUT - 1);
  localparam logic [2:0]  TRL_LAST = 3'(TRAILER_LEN - 1);
  localparam logic [2:0]  TRL_CMP  = 3'(TRL_DELAY_LINES_OFS);

  frame_state_e state, state_nxt;
  logic [31:0] byte_cnt;
  logic [31:0] idle_cnt;
  logic [2:0]  trl_cnt;
  logic        trl_ok;
  logic [31:0] al_shadow;
  logic [15:0] word_cnt;

  logic                  asm_vld_p0;
  logic                  asm_done_p0;
  logic [RESOLUTION-1:0] asm_word_p0;
  logic                  timeout_hit;
  logic                  byte_match;
  logic                  trl_last;
  logic                  frame_good;

  // Stage p0: byte intake and word assembly
  assign asm_vld_p0 = rx_valid && (state == ST_IDLE || state == ST_PAYLOAD);

  corr_word_assembler #(
    .RESOLUTION(RESOLUTION)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (timeout_hit),
    .byte_in  (rx_byte),
    .byte_vld (asm_vld_p0),
    .word     (asm_word_p0),
    .word_done(asm_done_p0)
  );

  always_comb begin
    timeout_hit = (state != ST_IDLE) && !rx_valid && (idle_cnt == TO_LAST);
    byte_match  = (rx_byte == trailer_expect(int'(trl_cnt), DELAY_LINES, NUM_INPUTS,
                                             RESOLUTION));
    trl_last    = (state == ST_TRAILER) && rx_valid && (trl_cnt == TRL_LAST);
    frame_good  = trl_ok && byte_match;
    state_nxt   = state;
    case (state)
      ST_IDLE: begin
        if (rx_valid) state_nxt = (PB_LAST == 32'd0) ? ST_TRAILER : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (timeout_hit) state_nxt = ST_IDLE;
        else if (rx_valid && byte_cnt == PB_LAST) state_nxt = ST_TRAILER;
      end
      ST_TRAILER: begin
        if (timeout_hit || trl_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: framing state, trailer check and the one-deep word buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
      trl_cnt     <= '0;
      trl_ok      <= 1'b1;
      al_shadow   <= '0;
      word_cnt    <= '0;
      word_valid  <= 1'b0;
      word_data   <= '0;
      word_index  <= '0;
      active_line <= '0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_ok  <= trl_last && frame_good;
      frame_err <= (trl_last && !frame_good) || timeout_hit;

      if (state == ST_IDLE || rx_valid || timeout_hit) idle_cnt <= '0;
      else idle_cnt <= idle_cnt + 32'd1;

      if (timeout_hit) byte_cnt <= '0;
      else if (asm_vld_p0) begin
        if (state == ST_IDLE) byte_cnt <= 32'd1;
        else byte_cnt <= (byte_cnt == PB_LAST) ? 32'd0 : byte_cnt + 32'd1;
      end

      if (timeout_hit) trl_cnt <= '0;
      else if (state == ST_TRAILER && rx_valid) trl_cnt <= trl_cnt + 3'd1;

      if (state != ST_TRAILER) trl_ok <= 1'b1;
      else if (rx_valid && trl_cnt >= TRL_CMP && !byte_match) trl_ok <= 1'b0;

      if (state == ST_TRAILER && rx_valid && trl_cnt < TRL_CMP)
        al_shadow[{trl_cnt[1:0], 3'b000} +: 8] <= rx_byte;

      if (trl_last && frame_good) active_line <= al_shadow;

      // A completion into a full buffer is dropped unless the buffer drains this cycle
      if (timeout_hit || trl_last) begin
        word_cnt <= '0;
        if (word_valid && word_ready) word_valid <= 1'b0;
      end else if (asm_done_p0) begin
        word_cnt <= word_cnt + 16'd1;
        if (!word_valid || word_ready) begin
          word_data  <= asm_word_p0;
          word_index <= word_cnt;
          word_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/corr_frame_rx.md
CORR_FRAME_RX -- requirements
Module: corr_frame_rx

Interface
REQ-001 SHALL have parameter RESOLUTION, default 16, counter width in bits, a multiple of 8.
REQ-002 SHALL have parameter NUM_INPUTS, default 8, number of pulse inputs in the sending correlator.
REQ-003 SHALL have parameter DELAY_LINES, default 51, delay taps per correlator pair.
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 4096, silent clk cycles that end or abort a frame.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port rx_byte, input, 8, received UART byte.
REQ-008 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_byte.
REQ-009 SHALL have port word_data, output, RESOLUTION, reassembled counter value.
REQ-010 SHALL have port word_index, output, 16, position of word_data in the frame, starting at 0.
REQ-011 SHALL have port word_valid, output, 1, word_data/word_index valid.
REQ-012 SHALL have port word_ready, input, 1, consumer accepts the word when word_valid is high.
REQ-013 SHALL have port active_line, output, 32, active_line field of the last good frame.
REQ-014 SHALL have port frame_ok, output, 1, one-cycle pulse on a valid trailer.
REQ-015 SHALL have port frame_err, output, 1, one-cycle pulse on a bad trailer or mid-frame timeout.
REQ-016 SHALL have port overrun, output, 1, sticky flag set when a completed word is dropped.

Function
REQ-017 SHALL define NUM_WORDS = NUM_INPUTS*(NUM_INPUTS-1)/2*DELAY_LINES + NUM_INPUTS, PAYLOAD_BYTES = NUM_WORDS*RESOLUTION/8, and frame length PAYLOAD_BYTES+8.
REQ-018 SHALL treat the byte stream as least-significant byte first, each word least-significant byte first, with the payload followed by an 8-byte trailer: active_line[31:0], DELAY_LINES, NUM_INPUTS, RESOLUTION, 0x00.
REQ-019 SHALL implement the states IDLE, PAYLOAD, and TRAILER.
REQ-020 SHALL move from IDLE to PAYLOAD on any rx_valid, using that byte as byte 0.
REQ-021 SHALL move from PAYLOAD to TRAILER after PAYLOAD_BYTES bytes.
REQ-022 SHALL move from TRAILER to IDLE after 8 trailer bytes.
REQ-023 SHALL compare trailer bytes 4..7 against the parameters; on full match, pulse frame_ok and latch active_line on the cycle after the last byte.
REQ-024 SHALL, on any trailer mismatch, pulse frame_err and leave active_line unchanged.
REQ-025 SHALL count clk cycles without rx_valid while in PAYLOAD or TRAILER; on reaching IDLE_TIMEOUT it SHALL pulse frame_err, discard the partial word, and return to IDLE.
REQ-026 SHALL, with the timeout counter in IDLE, make the next byte start a new frame.
REQ-027 SHALL raise word_valid one cycle after the byte that completes a word, with latency 1.
REQ-028 SHALL hold word_data and word_index stable until word_valid and word_ready are high in the same cycle.
REQ-029 SHALL, if a word completes while an unaccepted word is pending, keep the pending word, drop the new word, and set overrun until rst.
REQ-030 SHALL treat acceptance and completion of a new word in the same cycle as a clean handoff, with no overrun.
REQ-031 SHALL never emit trailer bytes as words.

Reset
REQ-032 SHALL, on rst, synchronously set state to IDLE, clear all counters, and set word_valid, frame_ok, frame_err, and overrun to 0.
REQ-033 SHALL, on rst, clear active_line, word_data, and word_index to 0.
REQ-034 SHALL, on rst asserted mid-frame, drop the partial frame with no frame_err pulse.

Structure
REQ-035 SHALL place NUM_WORDS, PAYLOAD_BYTES, the trailer length 8, the trailer field offsets, and the state encoding in shared package corr_frame_pkg.
REQ-036 SHALL contain one sub-module, corr_word_assembler, that shifts bytes into a RESOLUTION-bit word and flags completion.

Verification (NUM_INPUTS=3, DELAY_LINES=3, RESOLUTION=16 -> 12 words, 32-byte frame)
REQ-037 SHALL cover: one frame with word k = 0x1000+k, trailer 05 00 00 00 03 03 10 00, word_ready=1 -> 12 words, indices 0..11, values correct; frame_ok pulse; active_line=5.
REQ-038 SHALL cover: same frame with trailer byte 6 = 0x08 -> all 12 words emitted; frame_err pulse; active_line retains its previous value.
REQ-039 SHALL cover: 10 bytes, then IDLE_TIMEOUT silent cycles, then a good frame -> frame_err once; the good frame then decodes with indices from 0.
REQ-040 SHALL cover: word_ready=0 for the whole frame -> word 0 held; overrun set after word 1 completes; after word_ready=1, only word 0 is delivered.
REQ-041 SHALL cover: word_ready pulsed exactly on each completion cycle -> no overrun.
REQ-042 SHALL cover: rst asserted at byte 20 -> outputs cleared next cycle, no frame_err, next frame decodes correctly.
